// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch stage: registered read port with valid/stall
// handshake, run-time loader port, alignment/range faults, and a boot-clear sequencer.
module instr_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              stall,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              fault_misaligned,
    output logic              fault_range,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_FULL = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Fetch-side decode: the range test uses the whole word address so that
    // high address bits can never alias into the array.
    logic              fetch_misaligned;
    logic              fetch_out_of_range;
    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_accept;
    logic [DATA_W-1:0] read_word;

    assign fetch_misaligned   = (fetch_addr[1:0] != 2'b00);
    assign fetch_out_of_range = ({2'b00, fetch_addr[ADDR_W-1:2]} >= DEPTH_FULL);
    assign fetch_idx          = fetch_addr[IDX_W+1:2];
    assign fetch_ready        = (state == RUN) && !stall;
    assign fetch_accept       = fetch_req && fetch_ready;
    assign busy               = (state == CLEAR);

    // Loader-side decode.
    logic             load_misaligned;
    logic             load_out_of_range;
    logic [IDX_W-1:0] load_idx;
    logic             load_wr;

    assign load_misaligned   = (load_addr[1:0] != 2'b00);
    assign load_out_of_range = ({2'b00, load_addr[ADDR_W-1:2]} >= DEPTH_FULL);
    assign load_idx          = load_addr[IDX_W+1:2];
    assign load_wr           = (state == RUN) && load_en && !load_misaligned && !load_out_of_range;

    // Write-first bypass: a same-edge load to the fetched word wins over the array.
    always_comb begin
        read_word = mem[fetch_idx];
        if (load_wr && (load_idx == fetch_idx)) begin
            read_word = load_data;
        end
    end

    // NOTE: the array has no reset branch; clearing thousands of bits in one cycle
    // would defeat RAM inference, so the clear sequencer owns initialisation instead.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (load_wr) begin
            mem[load_idx] <= load_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= CLEAR;
            clr_cnt          <= '0;
            instr_valid      <= 1'b0;
            instruction      <= '0;
            fault_misaligned <= 1'b0;
            fault_range      <= 1'b0;
            load_err         <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt  <= clr_cnt + 1'b1;
                    load_err <= load_en;
                    if (clr_cnt == LAST_IDX) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    load_err <= load_en && (load_misaligned || load_out_of_range);
                end
                default: state <= CLEAR;
            endcase

            // Output register: capture on accept, freeze on stall, otherwise drop valid.
            if (fetch_accept) begin
                instr_valid      <= 1'b1;
                fault_misaligned <= fetch_misaligned;
                fault_range      <= fetch_out_of_range;
                instruction      <= (fetch_misaligned || fetch_out_of_range) ? '0 : read_word;
            end else if (!stall) begin
                instr_valid      <= 1'b0;
                fault_misaligned <= 1'b0;
                fault_range      <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the fetch stage. It adds a registered read port with a valid/stall handshake, a run-time loader write port, and alignment/range fault detection. After reset, a boot-clear sequencer fills every word with NOP (all zeros), so no stale program executes. The block sits between the PC/fetch logic and the decode stage.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 256, number of instruction words
ADDR_W, 32, byte-address width of fetch and load addresses
IDX_W, $clog2(DEPTH), word-index width (derived, not overridable)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch request, sampled when fetch_ready=1
fetch_addr  in  ADDR_W  byte address of the instruction
stall  in  1  downstream stall; holds outputs and blocks new requests
fetch_ready  out  1  block can accept a fetch this cycle
instr_valid  out  1  instruction holds the result of an accepted fetch
instruction  out  DATA_W  registered instruction word
fault_misaligned  out  1  accepted fetch had fetch_addr[1:0] != 0
fault_range  out  1  accepted fetch had word index >= DEPTH
load_en  in  1  loader write strobe
load_addr  in  ADDR_W  loader byte address
load_data  in  DATA_W  loader write data
load_err  out  1  one-cycle pulse: last load_en was rejected
busy  out  1  boot-clear in progress

Behaviour:
- Reset (async, immediate) sets:
  - state=CLEAR, clr_cnt=0
  - instr_valid=0, instruction=0, fault_misaligned=0, fault_range=0, load_err=0
  - busy=1, fetch_ready=0
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes mem[clr_cnt]=0, then clr_cnt++.
  - The cycle that writes index DEPTH-1 transitions to RUN.
  - busy=1 for exactly DEPTH cycles after reset deasserts.
  - fetch_req is ignored.
  - load_en is rejected, with load_err pulsed the next cycle.
- RUN: busy=0. RUN is terminal until the next reset.
- fetch_ready = (state==RUN) & !stall. This is combinational.
- Accepted fetch (fetch_req & fetch_ready) at edge N. At edge N+1 (1-cycle latency):
  - instr_valid=1
  - idx = fetch_addr[ADDR_W-1:2]
  - fault_misaligned = (fetch_addr[1:0] != 0)
  - fault_range = (idx >= DEPTH), compared at full width with no truncation
  - if either fault is set, instruction=0 (NOP); otherwise instruction=mem[idx[IDX_W-1:0]]
- stall=1: instr_valid, instruction and both fault flags hold their values. No request is accepted.
- No accepted fetch and stall=0: next edge sets instr_valid=0 and clears the faults; instruction holds its last value.
- Back-to-back fetches are accepted every cycle (throughput 1/cycle).
- Loader in RUN:
  - load_en with aligned, in-range load_addr writes mem[load_addr[IDX_W+1:2]]=load_data at the edge.
  - A misaligned or out-of-range load_addr is dropped, and load_err=1 for the next cycle only.
- Loader writes are independent of stall.
- Same-edge write and accepted fetch to the same index: read is write-first, so the fetch returns the new load_data.
- Reset asserted mid-CLEAR or mid-RUN aborts immediately; CLEAR restarts from index 0. Memory contents are not guaranteed until the clear completes.
- Memory is a plain reg array with no reset on its contents; only the clear sequencer initialises it.

Test Plan:
- Release reset, DEPTH=256 -> busy=1 and fetch_ready=0 for exactly 256 cycles; then fetch 0x10 -> next cycle instr_valid=1, instruction=0x00000000, no faults.
- In RUN, load 0x08<=0x12345678, then fetch 0x08 -> instr_valid=1, instruction=0x12345678; load 0x0C and fetch 0x0C in the same cycle with data 0xCAFEF00D -> returns 0xCAFEF00D.
- Fetch 0x06 -> fault_misaligned=1, instruction=0; fetch 0x400 -> fault_range=1, instruction=0; load to 0x401 -> load_err pulses for 1 cycle and memory is unchanged.
- Stream fetches 0x00,0x04,0x08, raising stall for 3 cycles after the first -> instruction/instr_valid frozen, fetch_ready=0, no request lost; the remaining words follow in order after stall drops.
- Assert reset at clear cycle 100 -> outputs zero immediately; after release busy lasts a full 256 cycles; load_en during CLEAR -> load_err=1 and no write.
- Drop fetch_req for 1 cycle in RUN -> instr_valid=0, instruction retains the previous word, faults cleared.
